stoch_nmax_window_ctrl: RTL and testbench

STOCH_NMAX_WINDOW_CTRL -- requirements
Module: stoch_nmax_window_ctrl

---
 rtl/stoch_ctrl_pkg.sv | 49 ++++
 rtl/stoch_signed_accum.sv | 27 ++
 rtl/stoch_nmax_window_ctrl.sv | 125 ++++++++++++
 tb/tb_stoch_nmax_window_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_ctrl_pkg.sv
// Shared types for the stochastic n-max window controller.
// State encoding, default widths and the Moore output decode.
package stoch_ctrl_pkg;

  localparam int WINDOW_BITS_DEF = 10;
  localparam int WARMUP_BITS_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WARMUP,
    S_RUN,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic dp_clr;
    logic dp_en;
    logic busy;
    logic result_valid;
  } ctrl_out_t;

  function automatic ctrl_out_t decode(state_t s);
    ctrl_out_t o;
    o = '0;
    unique case (s)
      S_IDLE:   o = '0;
      S_CLEAR:  begin
        o.dp_clr = 1'b1;
        o.busy   = 1'b1;
      end
      S_WARMUP: begin
        o.dp_en = 1'b1;
        o.busy  = 1'b1;
      end
      S_RUN:    begin
        o.dp_en = 1'b1;
        o.busy  = 1'b1;
      end
      S_HOLD:   begin
        o.busy         = 1'b1;
        o.result_valid = 1'b1;
      end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/stoch_signed_accum.sv
// Up/down counter of a signed bitstream pair.
// Width W+1 holds +/-(2^W-1) without wrapping.
module stoch_signed_accum #(
  parameter int W = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                enable,
  input  logic                y_p,
  input  logic                y_m,
  output logic signed [W:0]   count
);

  localparam logic signed [W:0] ONE = 1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (y_p ^ y_m)) begin
      count <= y_p ? count + ONE : count - ONE;
    end
  end

endmodule

// File: rtl/stoch_nmax_window_ctrl.sv
// Window controller: clear, warm-up, accumulate, hold result.
// Max tree lives outside; driven via dp_clr/dp_en.
import stoch_ctrl_pkg::*;

module stoch_nmax_window_ctrl #(
  parameter int WINDOW_BITS = WINDOW_BITS_DEF,
  parameter int WARMUP_BITS = WARMUP_BITS_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WINDOW_BITS-1:0]       window_len,
  input  logic [WARMUP_BITS-1:0]       warmup_len,
  input  logic                         y_p,
  input  logic                         y_m,
  output logic                         dp_clr,
  output logic                         dp_en,
  output logic                         busy,
  output logic signed [WINDOW_BITS:0]  result,
  output logic                         result_valid,
  input  logic                         result_ready
);

  state_t                  state;
  state_t                  nxt;
  ctrl_out_t               outs;
  logic [WINDOW_BITS-1:0]  cnt;
  logic [WINDOW_BITS-1:0]  cnt_nxt;
  logic [WINDOW_BITS-1:0]  win_q;
  logic [WARMUP_BITS-1:0]  warm_q;
  logic [WINDOW_BITS-1:0]  warm_ext;
  logic                    warm_last;
  logic                    run_last;
  logic                    accept;
  logic                    acc_en;

  assign warm_ext  = WINDOW_BITS'(warm_q);
  assign warm_last = (cnt == warm_ext - 1'b1);
  assign run_last  = (cnt == win_q - 1'b1);
  assign accept    = (state == S_IDLE) && start && !abort;
  assign acc_en    = (state == S_RUN) && !abort;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nxt     = S_CLEAR;
          cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        cnt_nxt = '0;
        if (warm_q != '0)
          nxt = S_WARMUP;
        else if (win_q != '0)
          nxt = S_RUN;
        else
          nxt = S_HOLD;
      end
      S_WARMUP: begin
        if (warm_last) begin
          cnt_nxt = '0;
          nxt     = (win_q != '0) ? S_RUN : S_HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (run_last) begin
          cnt_nxt = '0;
          nxt     = S_HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (result_ready)
          nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    // abort overrides start and the result handshake
    if (abort)
      nxt = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      win_q  <= '0;
      warm_q <= '0;
      outs   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      outs  <= decode(nxt);
      if (accept) begin
        win_q  <= window_len;
        warm_q <= warmup_len;
      end
    end
  end

  assign dp_clr       = outs.dp_clr;
  assign dp_en        = outs.dp_en;
  assign busy         = outs.busy;
  assign result_valid = outs.result_valid;

  stoch_signed_accum #(
    .W (WINDOW_BITS)
  ) u_accum (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (accept),
    .enable (acc_en),
    .y_p    (y_p),
    .y_m    (y_m),
    .count  (result)
  );

endmodule

// File: tb/tb_stoch_nmax_window_ctrl.sv
// Directed vector bench for stoch_nmax_window_ctrl.
// Table of windows plus abort/reset/hold sequences.
module tb_stoch_nmax_window_ctrl;

  logic               CLK = 1'b0;
  logic               RST;
  logic               start;
  logic               abort;
  logic [9:0]         window_len;
  logic [5:0]         warmup_len;
  logic               y_p;
  logic               y_m;
  logic               dp_clr;
  logic               dp_en;
  logic               busy;
  logic signed [10:0] result;
  logic               result_valid;
  logic               result_ready;

  stoch_nmax_window_ctrl #(
    .WINDOW_BITS (10),
    .WARMUP_BITS (6)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .abort        (abort),
    .window_len   (window_len),
    .warmup_len   (warmup_len),
    .y_p          (y_p),
    .y_m          (y_m),
    .dp_clr       (dp_clr),
    .dp_en        (dp_en),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    int    w;
    int    l;
    int    mode;
    int    exp_res;
  } vec_t;

  int   errs   = 0;
  int   checks = 0;
  int   cur_mode = 0;
  bit   ph = 1'b0;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_y();
    case (cur_mode)
      0: begin y_p = 1'b1; y_m = 1'b0; end
      1: begin y_p = 1'b0; y_m = 1'b1; end
      2: begin y_p = ph;   y_m = ~ph;  end
      3: begin y_p = 1'b1; y_m = 1'b1; end
      default: begin y_p = 1'b0; y_m = 1'b0; end
    endcase
  endtask

  task automatic tick();
    set_y();
    @(posedge CLK);
    #1;
    ph = ~ph;
  endtask

  task automatic start_win(input int w, input int l);
    warmup_len = 6'(w);
    window_len = 10'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    warmup_len = 6'($urandom);
    window_len = 10'($urandom);
  endtask

  task automatic run_to_hold(input string name, input int w, input int l,
                             output int e, output int clr_n,
                             output int en_n);
    start_win(w, l);
    e = 0;
    clr_n = int'(dp_clr);
    en_n = int'(dp_en);
    while (!result_valid && e < 3000) begin
      tick();
      e++;
      clr_n += int'(dp_clr);
      en_n += int'(dp_en);
    end
    if (!result_valid)
      chk({name, " timeout"}, 0, 1);
  endtask

  task automatic check_vec(input string name, input int w, input int l,
                           input int mode, input int exp);
    int e, clr_n, en_n;
    cur_mode = mode;
    run_to_hold(name, w, l, e, clr_n, en_n);
    chk({name, " dp_clr cycles"}, clr_n, 1);
    chk({name, " dp_en cycles"}, en_n, w + l);
    chk({name, " valid edge"}, e, 1 + w + l);
    chk({name, " result"}, int'(result), exp);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({name, " hold valid"}, int'(result_valid), 1);
      chk({name, " hold result"}, int'(result), exp);
      chk({name, " hold dp_en"}, int'(dp_en), 0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({name, " post valid"}, int'(result_valid), 0);
    chk({name, " post busy"}, int'(busy), 0);
    chk({name, " idle result"}, int'(result), exp);
  endtask

  initial begin
    int e, clr_n, en_n;
    bit seen;
    vecs[0] = '{"w4l8", 4, 8, 0, 8};
    vecs[1] = '{"w0l16alt", 0, 16, 2, 0};
    vecs[2] = '{"w3l0", 3, 0, 0, 0};
    vecs[3] = '{"l1023neg", 0, 1023, 1, -1023};
    vecs[4] = '{"both11", 1, 6, 3, 0};
    vecs[5] = '{"w2l5neg", 2, 5, 1, -5};
    vecs[6] = '{"w63l3", 63, 3, 0, 3};
    vecs[7] = '{"w0l0", 0, 0, 4, 0};

    RST = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    result_ready = 1'b0;
    window_len = '0;
    warmup_len = '0;
    y_p = 1'b0;
    y_m = 1'b0;
    #12;
    chk("rst dp_clr", int'(dp_clr), 0);
    chk("rst dp_en", int'(dp_en), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst valid", int'(result_valid), 0);
    chk("rst result", int'(result), 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      check_vec(vecs[i].name, vecs[i].w, vecs[i].l, vecs[i].mode,
                vecs[i].exp_res);

    // abort in third RUN cycle: two increments already taken
    cur_mode = 0;
    seen = 1'b0;
    start_win(2, 8);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
    chk("abort in run", int'(dp_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort dp_en", int'(dp_en), 0);
    chk("abort valid", int'(result_valid), 0);
    chk("abort result", int'(result), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (result_valid || busy) seen = 1'b1;
    end
    chk("abort never valid", int'(seen), 0);
    check_vec("after abort", 1, 4, 0, 4);

    // reset pulse during warm-up
    start_win(10, 4);
    tick();
    tick();
    tick();
    chk("pre rst busy", int'(busy), 1);
    RST = 1'b1;
    #2;
    chk("mid rst dp_clr", int'(dp_clr), 0);
    chk("mid rst dp_en", int'(dp_en), 0);
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst valid", int'(result_valid), 0);
    chk("mid rst result", int'(result), 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    chk("post rst idle", int'(busy), 0);
    check_vec("after rst", 3, 6, 0, 6);

    // start while in HOLD, also on the handshake edge
    cur_mode = 1;
    run_to_hold("hold start", 0, 3, e, clr_n, en_n);
    chk("hold start result", int'(result), -3);
    start = 1'b1;
    tick();
    chk("hold start valid", int'(result_valid), 1);
    chk("hold start dp_clr", int'(dp_clr), 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    chk("handshake start busy", int'(busy), 0);
    chk("handshake start dp_clr", int'(dp_clr), 0);
    tick();
    chk("handshake start idle", int'(busy), 0);
    chk("handshake idle result", int'(result), -3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
